// File: rtl/mem_bist_engine.sv
// mem_bist_engine: run-time memory built-in self-test sequencer.
//
// On an accepted start it writes a selectable data pattern across DEPTH consecutive
// locations starting at BASE_ADDR, reads the window back, compares each read
// against the expected value READ_LAT cycles after issue, and reports the result.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start, pattern_sel    run request (honoured only when idle) and pattern select:
//                         0 checkerboard, 1 address-as-data, 2 walking one,
//                         3 inverted checkerboard
//   busy, done, pass      run in progress, one-cycle end-of-run pulse, last result
//   err_count             saturating mismatch count of the current/last run
//   first_err_addr        address of the first mismatch of the run
//   mem_*                 bus-master side of the memory under test
//   mem_rdata             read data from the memory
// All outputs are registered.
module mem_bist_engine #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned ERR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_write,
  output logic              mem_enable,
  output logic              mem_output_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);
  localparam logic [2:0] LastDrain = 3'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrite = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       drain_q, drain_d;
  logic [1:0]       sel_q, sel_d;

  // Expected-data pipeline; stage READ_LAT lines up with the returning read data.
  logic              pipe_vld_q  [READ_LAT+1];
  logic [DATA_W-1:0] pipe_exp_q  [READ_LAT+1];
  logic [ADDR_W-1:0] pipe_addr_q [READ_LAT+1];

  logic              start_ok;
  logic              mismatch;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] next_data;
  logic              push;

  logic              busy_d, done_d, pass_d;
  logic [ERR_W-1:0]  err_count_d;
  logic [ADDR_W-1:0] first_err_addr_d;
  logic [ADDR_W-1:0] mem_address_d;
  logic              mem_read_write_d, mem_enable_d, mem_output_en_d, mem_wdata_oe_d;
  logic [DATA_W-1:0] mem_wdata_d;

  function automatic logic [DATA_W-1:0] pattern_data(input logic [1:0]        sel,
                                                     input logic [IDX_W-1:0]  idx,
                                                     input logic [ADDR_W-1:0] addr);
    logic [7:0]               byte_pat;
    logic [DATA_W+ADDR_W-1:0] addr_ext;
    logic [DATA_W-1:0]        d;
    byte_pat = idx[0] ? 8'hA5 : 8'h5A;
    addr_ext = {{DATA_W{1'b0}}, addr};
    d = '0;
    case (sel)
      2'd1: d = addr_ext[DATA_W-1:0];
      2'd2: d = DATA_W'(1) << (32'(idx) % DATA_W);
      default: begin
        // Replicate the byte pattern bit by bit so odd widths truncate cleanly.
        for (int k = 0; k < int'(DATA_W); k++) begin
          d[k] = byte_pat[k[2:0]];
        end
        if (sel == 2'd3) begin
          d = ~d;
        end
      end
    endcase
    return d;
  endfunction

  // Sequencer next state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    sel_d    = sel_q;
    start_ok = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = StWrite;
          idx_d    = '0;
          sel_d    = pattern_sel;
        end
      end
      StWrite: begin
        if (idx_q == LastIdx) begin
          state_d = StRead;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StRead: begin
        if (idx_q == LastIdx) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == LastDrain) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are computed from the next state so the registered bus matches it.
  always_comb begin
    next_addr = BaseAddr + ADDR_W'(idx_d);
    next_data = pattern_data(sel_d, idx_d, next_addr);
    push      = (state_d == StRead);

    mem_enable_d     = (state_d == StWrite) || (state_d == StRead);
    mem_read_write_d = (state_d != StWrite);
    mem_output_en_d  = (state_d == StRead);
    mem_wdata_oe_d   = (state_d == StWrite);
    mem_wdata_d      = (state_d == StWrite) ? next_data : '0;
    mem_address_d    = mem_enable_d ? next_addr : mem_address;
  end

  // Status and result bookkeeping.
  always_comb begin
    mismatch = pipe_vld_q[READ_LAT] && (mem_rdata != pipe_exp_q[READ_LAT]);

    busy_d           = (state_d != StIdle);
    done_d           = (state_q == StDone);
    pass_d           = pass;
    err_count_d      = err_count;
    first_err_addr_d = first_err_addr;

    if (start_ok) begin
      pass_d           = 1'b0;
      err_count_d      = '0;
      first_err_addr_d = '0;
    end else begin
      if (mismatch) begin
        if (err_count != ErrMax) begin
          err_count_d = err_count + 1'b1;
        end
        // Saturation never returns to zero, so zero means no mismatch seen yet.
        if (err_count == '0) begin
          first_err_addr_d = pipe_addr_q[READ_LAT];
        end
      end
      if (state_q == StDone) begin
        pass_d = (err_count == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      drain_q        <= '0;
      sel_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      mem_address    <= BaseAddr;
      mem_read_write <= 1'b1;
      mem_enable     <= 1'b0;
      mem_output_en  <= 1'b0;
      mem_wdata      <= '0;
      mem_wdata_oe   <= 1'b0;
      for (int k = 0; k <= int'(READ_LAT); k++) begin
        pipe_vld_q[k]  <= 1'b0;
        pipe_exp_q[k]  <= '0;
        pipe_addr_q[k] <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      drain_q        <= drain_d;
      sel_q          <= sel_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_count_d;
      first_err_addr <= first_err_addr_d;
      mem_address    <= mem_address_d;
      mem_read_write <= mem_read_write_d;
      mem_enable     <= mem_enable_d;
      mem_output_en  <= mem_output_en_d;
      mem_wdata      <= mem_wdata_d;
      mem_wdata_oe   <= mem_wdata_oe_d;
      pipe_vld_q[0]  <= push;
      pipe_exp_q[0]  <= push ? next_data : '0;
      pipe_addr_q[0] <= push ? next_addr : '0;
      for (int k = 1; k <= int'(READ_LAT); k++) begin
        pipe_vld_q[k]  <= pipe_vld_q[k-1];
        pipe_exp_q[k]  <= pipe_exp_q[k-1];
        pipe_addr_q[k] <= pipe_addr_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_bist_engine.sv
// Bench for mem_bist_engine: three instances with different geometries, each with
// its own behavioural memory (configurable stuck-at-1 bit or all-zero reads).
// Expected bus operations are queued when a run is launched and checked as the
// DUT drives them; run results come from a table of hand-derived values.
module tb_mem_bist_engine;

  localparam int DEP  [3] = '{4, 20, 4};
  localparam int RL   [3] = '{1, 1, 3};
  localparam int BASE [3] = '{0, 0, 'hFFFE};

  logic        clk = 1'b0;
  logic        reset;
  logic        st    [3];
  logic [1:0]  sel   [3];
  logic        busy  [3];
  logic        done  [3];
  logic        pass  [3];
  logic [15:0] first [3];
  logic [15:0] maddr [3];
  logic        mrw   [3];
  logic        men   [3];
  logic        moe   [3];
  logic [15:0] wd    [3];
  logic        wdoe  [3];
  logic [15:0] rd    [3];
  logic [15:0] err0, err2;
  logic [1:0]  err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bist_engine #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .BASE_ADDR(0), .READ_LAT(1),
                    .ERR_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .start(st[0]), .pattern_sel(sel[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .err_count(err0), .first_err_addr(first[0]),
    .mem_address(maddr[0]), .mem_read_write(mrw[0]), .mem_enable(men[0]),
    .mem_output_en(moe[0]), .mem_wdata(wd[0]), .mem_wdata_oe(wdoe[0]), .mem_rdata(rd[0])
  );

  mem_bist_engine #(.DATA_W(16), .ADDR_W(16), .DEPTH(20), .BASE_ADDR(0), .READ_LAT(1),
                    .ERR_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(st[1]), .pattern_sel(sel[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .err_count(err1), .first_err_addr(first[1]),
    .mem_address(maddr[1]), .mem_read_write(mrw[1]), .mem_enable(men[1]),
    .mem_output_en(moe[1]), .mem_wdata(wd[1]), .mem_wdata_oe(wdoe[1]), .mem_rdata(rd[1])
  );

  mem_bist_engine #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .BASE_ADDR('hFFFE), .READ_LAT(3),
                    .ERR_W(16)) u_dut2 (
    .clk(clk), .reset(reset), .start(st[2]), .pattern_sel(sel[2]), .busy(busy[2]),
    .done(done[2]), .pass(pass[2]), .err_count(err2), .first_err_addr(first[2]),
    .mem_address(maddr[2]), .mem_read_write(mrw[2]), .mem_enable(men[2]),
    .mem_output_en(moe[2]), .mem_wdata(wd[2]), .mem_wdata_oe(wdoe[2]), .mem_rdata(rd[2])
  );

  // Behavioural memories: write on enabled write cycles, read data RL edges later.
  logic [15:0] mem        [3][256];
  logic [15:0] rpipe      [3][3];
  int          stuck_addr [3] = '{-1, -1, -1};
  logic [15:0] stuck_mask [3] = '{16'h0, 16'h0, 16'h0};
  bit          zero_mem   [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (men[k] && !mrw[k]) mem[k][maddr[k][7:0]] <= wd[k];
      if (men[k] && mrw[k]) begin
        if (zero_mem[k]) rpipe[k][0] <= 16'h0;
        else rpipe[k][0] <= mem[k][maddr[k][7:0]] |
                            ((int'(maddr[k]) == stuck_addr[k]) ? stuck_mask[k] : 16'h0);
      end else begin
        rpipe[k][0] <= 16'h0;
      end
      rpipe[k][1] <= rpipe[k][0];
      rpipe[k][2] <= rpipe[k][1];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) rd[k] = rpipe[k][RL[k]-1];
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [31:0] err_of(input int k);
    if (k == 0) return {16'h0, err0};
    if (k == 1) return {30'h0, err1};
    return {16'h0, err2};
  endfunction

  function automatic logic [15:0] pat_model(input logic [1:0] p, input int i,
                                            input logic [15:0] a);
    case (p)
      2'd0:    return (i % 2 == 0) ? 16'h5A5A : 16'hA5A5;
      2'd3:    return (i % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
      2'd1:    return a;
      default: return 16'h0001 << (i % 16);
    endcase
  endfunction

  // Scoreboard of expected bus operations.
  typedef struct {
    int          inst;
    logic [15:0] addr;
    logic        rw;
    logic [15:0] data;
  } bus_t;
  bus_t exp_q[$];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (men[k]) begin
        if (exp_q.size() == 0) begin
          chk("bus_unexpected_op", {31'h0, men[k]}, 32'h0);
        end else begin
          bus_t e;
          e = exp_q.pop_front();
          chk("bus_inst", k, e.inst);
          chk("bus_addr", {16'h0, maddr[k]}, {16'h0, e.addr});
          chk("bus_rw", {31'h0, mrw[k]}, {31'h0, e.rw});
          chk("bus_oe", {31'h0, moe[k]}, {31'h0, e.rw});
          chk("bus_wdata_oe", {31'h0, wdoe[k]}, {31'h0, !e.rw});
          if (!e.rw) chk("bus_wdata", {16'h0, wd[k]}, {16'h0, e.data});
        end
      end else if (mrw[k] !== 1'b1 || moe[k] !== 1'b0 || wdoe[k] !== 1'b0) begin
        chk("bus_idle", {29'h0, mrw[k], moe[k], wdoe[k]}, 32'h4);
      end
    end
  end

  typedef struct {
    int          inst;
    logic [1:0]  pat;
    int          s_addr;
    logic [15:0] s_mask;
    bit          zero;
    int          exp_err;
    logic [15:0] exp_first;
    bit          exp_pass;
    int          exp_cyc;
    bit          pulse_busy;
    bit          start_at_done;
  } vec_t;

  vec_t vecs[10];

  task automatic push_ops(input int k, input logic [1:0] p);
    logic [15:0] a;
    for (int i = 0; i < DEP[k]; i++) begin
      a = 16'(BASE[k] + i);
      exp_q.push_back('{k, a, 1'b0, pat_model(p, i, a)});
    end
    for (int i = 0; i < DEP[k]; i++) begin
      a = 16'(BASE[k] + i);
      exp_q.push_back('{k, a, 1'b1, 16'h0});
    end
  endtask

  task automatic check_reset(input int k);
    chk("rst_busy", {31'h0, busy[k]}, 32'h0);
    chk("rst_done", {31'h0, done[k]}, 32'h0);
    chk("rst_pass", {31'h0, pass[k]}, 32'h0);
    chk("rst_err", err_of(k), 32'h0);
    chk("rst_first", {16'h0, first[k]}, 32'h0);
    chk("rst_addr", {16'h0, maddr[k]}, 32'(BASE[k]));
    chk("rst_rw", {31'h0, mrw[k]}, 32'h1);
    chk("rst_en", {31'h0, men[k]}, 32'h0);
    chk("rst_oe", {31'h0, moe[k]}, 32'h0);
    chk("rst_wdata", {16'h0, wd[k]}, 32'h0);
    chk("rst_wdata_oe", {31'h0, wdoe[k]}, 32'h0);
  endtask

  task automatic run(input vec_t v);
    int k;
    int cyc;
    bit got;
    k = v.inst;
    stuck_addr[k] = v.s_addr;
    stuck_mask[k] = v.s_mask;
    zero_mem[k]   = v.zero;
    push_ops(k, v.pat);
    @(negedge clk);
    st[k]  = 1'b1;
    sel[k] = v.pat;
    @(posedge clk);
    #1;
    st[k] = 1'b0;
    chk("start_busy", {31'h0, busy[k]}, 32'h1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done[k]) begin
        got = 1'b1;
      end else begin
        st[k] = (v.pulse_busy && (cyc == 3 || cyc == 6)) ||
                (v.start_at_done && cyc == v.exp_cyc - 1);
        if (v.pulse_busy) sel[k] = v.pat ^ 2'b01;
      end
    end
    st[k] = 1'b0;
    chk("done_seen", {31'h0, got}, 32'h1);
    chk("run_cycles", cyc, v.exp_cyc);
    chk("done_busy", {31'h0, busy[k]}, 32'h0);
    chk("pass", {31'h0, pass[k]}, {31'h0, v.exp_pass});
    chk("err_count", err_of(k), v.exp_err);
    chk("first_err_addr", {16'h0, first[k]}, {16'h0, v.exp_first});
    @(posedge clk);
    #1;
    chk("done_pulse_len", {31'h0, done[k]}, 32'h0);
    chk("no_restart", {31'h0, busy[k]}, 32'h0);
    chk("pass_hold", {31'h0, pass[k]}, {31'h0, v.exp_pass});
    chk("ops_consumed", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int seen;
    for (int k = 0; k < 3; k++) begin
      st[k]  = 1'b0;
      sel[k] = 2'd0;
    end
    reset = 1'b1;

    //           inst pat  s_addr s_mask  zero err first  pass cyc busy done
    vecs[0] = '{0, 2'd0, -1, 16'h0000, 1'b0, 0, 16'h0000, 1'b1, 10, 1'b1, 1'b0};
    vecs[1] = '{1, 2'd2, -1, 16'h0000, 1'b0, 0, 16'h0000, 1'b1, 42, 1'b0, 1'b1};
    vecs[2] = '{1, 2'd1,  2, 16'h0008, 1'b0, 1, 16'h0002, 1'b0, 42, 1'b0, 1'b0};
    vecs[3] = '{1, 2'd0, -1, 16'h0000, 1'b1, 3, 16'h0000, 1'b0, 42, 1'b0, 1'b0};
    vecs[4] = '{2, 2'd1, -1, 16'h0000, 1'b0, 0, 16'h0000, 1'b1, 12, 1'b0, 1'b0};
    vecs[5] = '{0, 2'd1,  3, 16'h8000, 1'b0, 1, 16'h0003, 1'b0, 10, 1'b0, 1'b0};
    vecs[6] = '{0, 2'd3, -1, 16'h0000, 1'b0, 0, 16'h0000, 1'b1, 10, 1'b0, 1'b1};
    vecs[7] = '{2, 2'd0, -1, 16'h0000, 1'b1, 4, 16'hFFFE, 1'b0, 12, 1'b1, 1'b0};
    vecs[8] = '{0, 2'd2, -1, 16'h0000, 1'b1, 4, 16'h0000, 1'b0, 10, 1'b0, 1'b0};
    vecs[9] = '{1, 2'd3, -1, 16'h0000, 1'b0, 0, 16'h0000, 1'b1, 42, 1'b0, 1'b0};

    #12;
    for (int k = 0; k < 3; k++) check_reset(k);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 10; n++) run(vecs[n]);

    // Abort mid-READ with reset: outputs return at once and no done follows.
    stuck_addr[0] = -1;
    zero_mem[0]   = 1'b0;
    push_ops(0, 2'd0);
    @(negedge clk);
    st[0]  = 1'b1;
    sel[0] = 2'd0;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    chk("pre_abort_read", {31'h0, mrw[0] & men[0]}, 32'h1);
    reset = 1'b1;
    #1;
    check_reset(0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done[0] || busy[0] || men[0]) seen++;
    end
    chk("no_done_after_abort", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
